// File: rtl/ps2_pkg.sv
// Shared constants and types for the PS/2 set-2 scan code decoder.
package ps2_pkg;

  localparam logic [7:0] SC_E0       = 8'hE0;
  localparam logic [7:0] SC_E1       = 8'hE1;
  localparam logic [7:0] SC_F0       = 8'hF0;
  localparam logic [7:0] SC_LSHIFT   = 8'h12;
  localparam logic [7:0] SC_RSHIFT   = 8'h59;
  localparam logic [7:0] SC_CAPS     = 8'h58;
  localparam logic [7:0] SC_KP_SLASH = 8'h4A;
  localparam logic [7:0] SC_KP_ENTER = 8'h5A;

  // Bytes still to discard after the E1 that opens the Pause sequence.
  localparam logic [2:0] SKIP_LEN = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK,
    ST_SKIP
  } dec_state_t;

endpackage

// File: rtl/ps2_scancode_decoder_if.sv
// Scan code input strobe and ASCII event valid/ready output of the decoder.
interface ps2_scancode_decoder_if;
  logic [7:0] scan_code;
  logic       scan_valid;
  logic [7:0] out_ascii;
  logic       out_valid;
  logic       out_ready;

  modport master (
    output scan_code, scan_valid, out_ready,
    input  out_ascii, out_valid
  );

  modport slave (
    input  scan_code, scan_valid, out_ready,
    output out_ascii, out_valid
  );
endinterface

// File: rtl/ps2_ascii_lut.sv
// Combinational set-2 make code to ASCII translation; 0x00 means no mapping.
module ps2_ascii_lut (
  input  logic [7:0] code,
  input  logic       shift,
  input  logic       caps,
  output logic [7:0] ascii
);
  logic [7:0] lo;
  logic [7:0] hi;
  logic       letter;
  logic       upper;

  always_comb begin
    lo = '0;
    hi = '0;
    case (code)
      8'h1C: {lo, hi} = {"a", "A"};  8'h32: {lo, hi} = {"b", "B"};  8'h21: {lo, hi} = {"c", "C"};
      8'h23: {lo, hi} = {"d", "D"};  8'h24: {lo, hi} = {"e", "E"};  8'h2B: {lo, hi} = {"f", "F"};
      8'h34: {lo, hi} = {"g", "G"};  8'h33: {lo, hi} = {"h", "H"};  8'h43: {lo, hi} = {"i", "I"};
      8'h3B: {lo, hi} = {"j", "J"};  8'h42: {lo, hi} = {"k", "K"};  8'h4B: {lo, hi} = {"l", "L"};
      8'h3A: {lo, hi} = {"m", "M"};  8'h31: {lo, hi} = {"n", "N"};  8'h44: {lo, hi} = {"o", "O"};
      8'h4D: {lo, hi} = {"p", "P"};  8'h15: {lo, hi} = {"q", "Q"};  8'h2D: {lo, hi} = {"r", "R"};
      8'h1B: {lo, hi} = {"s", "S"};  8'h2C: {lo, hi} = {"t", "T"};  8'h3C: {lo, hi} = {"u", "U"};
      8'h2A: {lo, hi} = {"v", "V"};  8'h1D: {lo, hi} = {"w", "W"};  8'h22: {lo, hi} = {"x", "X"};
      8'h35: {lo, hi} = {"y", "Y"};  8'h1A: {lo, hi} = {"z", "Z"};
      8'h16: {lo, hi} = {"1", "!"};  8'h1E: {lo, hi} = {"2", "@"};  8'h26: {lo, hi} = {"3", "#"};
      8'h25: {lo, hi} = {"4", "$"};  8'h2E: {lo, hi} = {"5", "%"};  8'h36: {lo, hi} = {"6", "^"};
      8'h3D: {lo, hi} = {"7", "&"};  8'h3E: {lo, hi} = {"8", "*"};  8'h46: {lo, hi} = {"9", "("};
      8'h45: {lo, hi} = {"0", ")"};
      8'h0E: {lo, hi} = {8'h60, 8'h7E};  8'h4E: {lo, hi} = {8'h2D, 8'h5F};  8'h55: {lo, hi} = {8'h3D, 8'h2B};
      8'h54: {lo, hi} = {8'h5B, 8'h7B};  8'h5B: {lo, hi} = {8'h5D, 8'h7D};  8'h5D: {lo, hi} = {8'h5C, 8'h7C};
      8'h4C: {lo, hi} = {8'h3B, 8'h3A};  8'h52: {lo, hi} = {8'h27, 8'h22};  8'h41: {lo, hi} = {8'h2C, 8'h3C};
      8'h49: {lo, hi} = {8'h2E, 8'h3E};  8'h4A: {lo, hi} = {8'h2F, 8'h3F};
      8'h29: {lo, hi} = {8'h20, 8'h20};
      8'h5A: {lo, hi} = {8'h0D, 8'h0D};
      8'h66: {lo, hi} = {8'h08, 8'h08};
      8'h0D: {lo, hi} = {8'h09, 8'h09};
      8'h76: {lo, hi} = {8'h1B, 8'h1B};
      default: {lo, hi} = '0;
    endcase
  end

  // Caps lock only affects letters; everything else follows shift alone.
  assign letter = (lo >= 8'h61) && (lo <= 8'h7A);
  assign upper  = letter ? (shift ^ caps) : shift;
  assign ascii  = upper ? hi : lo;

endmodule

// File: rtl/ps2_scancode_decoder.sv
// Set-2 prefix tracking, shift/caps state and ASCII event FIFO for a PS/2 keyboard.
module ps2_scancode_decoder
  import ps2_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  ps2_scancode_decoder_if.slave bus,
  output logic                 shift_state,
  output logic                 caps_lock,
  output logic                 overflow
);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  dec_state_t state_q, state_d;
  logic [2:0] skip_q, skip_d;
  logic       lshift_q, lshift_d;
  logic       rshift_q, rshift_d;
  logic       caps_q, caps_d;
  logic       push;
  logic [7:0] push_data;
  logic [7:0] lut_ascii;

  logic [7:0] mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        empty, full, pop, push_ok;

  assign shift_state = lshift_q | rshift_q;
  assign caps_lock   = caps_q;

  ps2_ascii_lut u_lut (
    .code  (bus.scan_code),
    .shift (shift_state),
    .caps  (caps_q),
    .ascii (lut_ascii)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      skip_q   <= '0;
      lshift_q <= 1'b0;
      rshift_q <= 1'b0;
      caps_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      skip_q   <= skip_d;
      lshift_q <= lshift_d;
      rshift_q <= rshift_d;
      caps_q   <= caps_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    skip_d    = skip_q;
    lshift_d  = lshift_q;
    rshift_d  = rshift_q;
    caps_d    = caps_q;
    push      = 1'b0;
    push_data = lut_ascii;
    if (bus.scan_valid) begin
      case (state_q)
        ST_IDLE: begin
          if (bus.scan_code == SC_E0)          state_d = ST_EXT;
          else if (bus.scan_code == SC_F0)     state_d = ST_BRK;
          else if (bus.scan_code == SC_E1) begin
            state_d = ST_SKIP;
            skip_d  = SKIP_LEN;
          end
          else if (bus.scan_code == SC_LSHIFT) lshift_d = 1'b1;
          else if (bus.scan_code == SC_RSHIFT) rshift_d = 1'b1;
          else if (bus.scan_code == SC_CAPS)   caps_d   = ~caps_q;
          else                                 push     = (lut_ascii != 8'h00);
        end
        ST_EXT: begin
          if (bus.scan_code == SC_F0) begin
            state_d = ST_EXT_BRK;
          end else begin
            state_d = ST_IDLE;
            if (bus.scan_code == SC_KP_SLASH) begin
              push      = 1'b1;
              push_data = 8'h2F;
            end else if (bus.scan_code == SC_KP_ENTER) begin
              push      = 1'b1;
              push_data = 8'h0D;
            end
          end
        end
        ST_BRK: begin
          state_d = ST_IDLE;
          if (bus.scan_code == SC_LSHIFT) lshift_d = 1'b0;
          if (bus.scan_code == SC_RSHIFT) rshift_d = 1'b0;
        end
        ST_EXT_BRK: state_d = ST_IDLE;
        ST_SKIP: begin
          if (skip_q <= 3'd1) begin
            skip_d  = '0;
            state_d = ST_IDLE;
          end else begin
            skip_d = skip_q - 3'd1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Pointers carry one extra MSB so full and empty differ after wrap.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop     = !empty && bus.out_ready;
  assign push_ok = push && (!full || pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (pop)     rd_ptr <= rd_ptr + (AW+1)'(1);
      if (push_ok) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (push && full && !pop) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  assign bus.out_valid = !empty;
  assign bus.out_ascii = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Randomised and directed checks of the scan code decoder against a table-driven reference.
module tb_ps2_scancode_decoder;
  logic clk = 1'b0;
  logic reset;
  logic shift_state, caps_lock, overflow;

  always #5 clk = ~clk;

  ps2_scancode_decoder_if bus ();

  ps2_scancode_decoder #(.FIFO_DEPTH(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus.slave),
    .shift_state (shift_state),
    .caps_lock   (caps_lock),
    .overflow    (overflow)
  );

  int n_vec = 0;
  int n_err = 0;

  byte unsigned letter_codes[26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                                     8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                                     8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  byte unsigned digit_codes[10]  = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46, 8'h45};
  byte unsigned punct_codes[11]  = '{8'h0E, 8'h4E, 8'h55, 8'h54, 8'h5B, 8'h5D, 8'h4C, 8'h52, 8'h41, 8'h49, 8'h4A};
  byte unsigned punct_lo[11]     = '{8'h60, 8'h2D, 8'h3D, 8'h5B, 8'h5D, 8'h5C, 8'h3B, 8'h27, 8'h2C, 8'h2E, 8'h2F};
  byte unsigned punct_hi[11]     = '{8'h7E, 8'h5F, 8'h2B, 8'h7B, 8'h7D, 8'h7C, 8'h3A, 8'h22, 8'h3C, 8'h3E, 8'h3F};
  byte unsigned spec_codes[5]    = '{8'h29, 8'h5A, 8'h66, 8'h0D, 8'h76};
  byte unsigned spec_ascii[5]    = '{8'h20, 8'h0D, 8'h08, 8'h09, 8'h1B};

  byte unsigned lo_tab[byte unsigned];
  byte unsigned hi_tab[byte unsigned];
  bit           is_letter[byte unsigned];
  byte unsigned key_pool[$];

  // Reference state
  byte unsigned m_q[$];
  bit m_ls, m_rs, m_caps, m_ovf, m_ext, m_brk;
  int m_skip;
  bit rdy;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic build_tables();
    string lw, dl, dh;
    lw = "abcdefghijklmnopqrstuvwxyz";
    dl = "1234567890";
    dh = "!@#$%^&*()";
    for (int unsigned i = 0; i < 26; i++) begin
      lo_tab[letter_codes[i]] = lw[i];
      hi_tab[letter_codes[i]] = lw[i] - 8'd32;
      is_letter[letter_codes[i]] = 1'b1;
      key_pool.push_back(letter_codes[i]);
    end
    for (int unsigned i = 0; i < 10; i++) begin
      lo_tab[digit_codes[i]] = dl[i];
      hi_tab[digit_codes[i]] = dh[i];
      is_letter[digit_codes[i]] = 1'b0;
      key_pool.push_back(digit_codes[i]);
    end
    for (int unsigned i = 0; i < 11; i++) begin
      lo_tab[punct_codes[i]] = punct_lo[i];
      hi_tab[punct_codes[i]] = punct_hi[i];
      is_letter[punct_codes[i]] = 1'b0;
      key_pool.push_back(punct_codes[i]);
    end
    for (int unsigned i = 0; i < 5; i++) begin
      lo_tab[spec_codes[i]] = spec_ascii[i];
      hi_tab[spec_codes[i]] = spec_ascii[i];
      is_letter[spec_codes[i]] = 1'b0;
      key_pool.push_back(spec_codes[i]);
    end
  endtask

  function automatic byte unsigned ref_ascii(input byte unsigned c);
    bit sh, up;
    if (!lo_tab.exists(c)) return 8'h00;
    sh = m_ls | m_rs;
    up = is_letter[c] ? (sh ^ m_caps) : sh;
    return up ? hi_tab[c] : lo_tab[c];
  endfunction

  task automatic model_reset();
    m_q.delete();
    {m_ls, m_rs, m_caps, m_ovf, m_ext, m_brk} = '0;
    m_skip = 0;
  endtask

  // Reference behaviour of one clock edge given the inputs presented before it.
  task automatic model_edge(input byte unsigned c, input bit v, input bit r);
    byte unsigned ev = 8'h00;
    bit do_pop = (m_q.size() > 0) && r;
    if (v) begin
      if (m_skip > 0) m_skip--;
      else if (c == 8'hE1 && !m_ext && !m_brk) m_skip = 7;
      else if (c == 8'hE0 && !m_ext && !m_brk) m_ext = 1'b1;
      else if (c == 8'hF0 && !m_brk) m_brk = 1'b1;
      else begin
        if (!m_ext && !m_brk) begin
          if (c == 8'h12) m_ls = 1'b1;
          else if (c == 8'h59) m_rs = 1'b1;
          else if (c == 8'h58) m_caps = !m_caps;
          else ev = ref_ascii(c);
        end else if (m_ext && !m_brk) begin
          ev = (c == 8'h4A) ? 8'h2F : (c == 8'h5A) ? 8'h0D : 8'h00;
        end else if (!m_ext && m_brk) begin
          if (c == 8'h12) m_ls = 1'b0;
          if (c == 8'h59) m_rs = 1'b0;
        end
        m_ext = 1'b0;
        m_brk = 1'b0;
      end
    end
    if (do_pop) void'(m_q.pop_front());
    if (ev != 8'h00) begin
      if (m_q.size() < 4) m_q.push_back(ev);
      else m_ovf = 1'b1;
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".valid"}, bus.out_valid, m_q.size() > 0);
    check({tag, ".ascii"}, bus.out_ascii, (m_q.size() > 0) ? m_q[0] : 8'h00);
    check({tag, ".shift"}, shift_state, m_ls | m_rs);
    check({tag, ".caps"},  caps_lock, m_caps);
    check({tag, ".ovf"},   overflow, m_ovf);
  endtask

  task automatic cycle(input byte unsigned c, input bit v, input string tag);
    @(negedge clk);
    bus.scan_code  = c;
    bus.scan_valid = v;
    bus.out_ready  = rdy;
    model_edge(c, v, rdy);
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic send(input byte unsigned c, input string tag);
    cycle(c, 1'b1, tag);
  endtask

  task automatic idle(input int unsigned n, input string tag);
    for (int unsigned i = 0; i < n; i++) cycle(8'h00, 1'b0, tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    bus.scan_valid = 1'b0;
    @(posedge clk);
    #1;
    model_reset();
    check_all("reset");
    reset = 1'b0;
  endtask

  initial begin
    byte unsigned c;
    int r;
    reset = 1'b0;
    bus.scan_code = 8'h00;
    bus.scan_valid = 1'b0;
    bus.out_ready = 1'b0;
    rdy = 1'b1;
    build_tables();
    do_reset();

    send(8'h1C, "make_a");
    idle(2, "drain_a");

    send(8'h12, "lshift"); send(8'h1C, "shift_a"); send(8'hF0, "brk");
    send(8'h1C, "brk_a");  send(8'hF0, "brk");     send(8'h12, "rel_shift");
    send(8'h1C, "plain_a");
    idle(2, "drain");

    send(8'h58, "caps"); send(8'hF0, "brk"); send(8'h58, "caps_brk");
    send(8'h1C, "caps_a"); send(8'h12, "lshift"); send(8'h16, "bang");
    send(8'h1C, "caps_shift_a");
    send(8'hF0, "brk"); send(8'h12, "rel_shift"); send(8'h58, "caps_off");
    send(8'hE0, "ext"); send(8'h4A, "kp_slash"); send(8'hE0, "ext"); send(8'h5A, "kp_enter");
    send(8'hE0, "ext"); send(8'h12, "fake_shift");
    send(8'hE0, "ext"); send(8'hF0, "ext_brk"); send(8'h4A, "ext_brk_code");
    idle(3, "drain");

    send(8'hE1, "pause"); send(8'h14, "pause"); send(8'h77, "pause"); send(8'hE1, "pause");
    send(8'hF0, "pause"); send(8'h14, "pause"); send(8'hF0, "pause"); send(8'h77, "pause");
    send(8'h1C, "post_pause");
    idle(2, "drain");

    rdy = 1'b0;
    send(8'h1C, "fill"); send(8'h32, "fill"); send(8'h21, "fill"); send(8'h23, "fill");
    send(8'h24, "overflow");
    idle(2, "hold");
    rdy = 1'b1;
    idle(5, "drain_full");

    rdy = 1'b0;
    for (int unsigned i = 0; i < 4; i++) send(8'h1C, "refill");
    rdy = 1'b1;
    send(8'h32, "push_pop_full");
    idle(5, "drain");

    send(8'h58, "caps"); send(8'hF0, "brk");
    do_reset();
    send(8'h1C, "post_reset_a");
    idle(2, "drain");

    for (int unsigned n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 499) == 0) begin
        do_reset();
        continue;
      end
      r = $urandom_range(0, 15);
      case (r)
        0:       c = 8'hE0;
        1:       c = 8'hF0;
        2:       c = ($urandom_range(0, 1) != 0) ? 8'h12 : 8'h59;
        3:       c = ($urandom_range(0, 3) == 0) ? 8'h58 : 8'h4A;
        4:       c = ($urandom_range(0, 7) == 0) ? 8'hE1 : 8'h5A;
        5:       c = 8'($urandom_range(0, 255));
        default: c = key_pool[$urandom_range(0, key_pool.size() - 1)];
      endcase
      rdy = ($urandom_range(0, 3) != 0);
      cycle(c, $urandom_range(0, 3) != 0, "rand");
    end

    rdy = 1'b1;
    idle(6, "final_drain");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
